sw_debounce: RTL and testbench

Per-bit synchronizer and debouncer for the DE10-Lite slide switches. It sits directly upstream of the switch PIO input port: raw asynchronous `SW[9:0]` pins enter, and stable, clock-domain-safe levels leave to drive the PIO's `in_port`. It also produces a one-cycle change pulse per bit for interrupt or edge logic.

---
 rtl/sw_debounce.sv | 96 +++++++++
 tb/tb_sw_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit two-flop synchronizer plus debouncer for the slide
// switches. A bit's level is accepted after DEBOUNCE_CYCLES consecutive
// cycles in which the synchronized input disagrees with the current output.
// Any return to the current level before then restarts that bit's count.
// Optional feature macro: SW_DEBOUNCE_EVENT_EN adds event_clr / event_q, a
// sticky per-bit change flag (a set and a clear in the same cycle leave the
// flag set).
module sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
`ifdef SW_DEBOUNCE_EVENT_EN
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] event_q,
`endif
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed
);

    // Terminal count: the level is accepted on the edge where the count
    // already equals this value, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sw_out;
    logic [WIDTH-1:0] r_sw_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_chg_nxt;

    // Per-bit next-state: clear on agreement, accept at terminal count, else count up.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_out_nxt[i] = r_sw_out[i];
            w_chg_nxt[i] = 1'b0;
            if (r_sync2[i] == r_sw_out[i]) begin
                w_cnt_nxt[i] = {CNT_W{1'b0}};
            end else if (r_cnt[i] == CNT_LAST) begin
                w_cnt_nxt[i] = {CNT_W{1'b0}};
                w_out_nxt[i] = r_sync2[i];
                w_chg_nxt[i] = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Synchronizer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= {WIDTH{1'b0}};
            r_sync2      <= {WIDTH{1'b0}};
            r_sw_out     <= {WIDTH{1'b0}};
            r_sw_changed <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            r_sync1      <= sw_in;
            r_sync2      <= r_sync1;
            r_sw_out     <= w_out_nxt;
            r_sw_changed <= w_chg_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign sw_out     = r_sw_out;
    assign sw_changed = r_sw_changed;

`ifdef SW_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] r_event_q;

    // Sticky change flags: a pulse sets, event_clr clears, set has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_q <= {WIDTH{1'b0}};
        end else begin
            r_event_q <= (r_event_q & ~event_clr) | r_sw_changed;
        end
    end

    assign event_q = r_event_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce with DEBOUNCE_CYCLES=4, WIDTH=10.
// A reference model runs every clock edge and pushes the expected outputs
// into a queue; a monitor pops and compares them on the falling edge.
// The model accepts a new level when the last DEBOUNCE_CYCLES synchronized
// samples all differ from the current output (a sliding-window rule).
module tb_sw_debounce;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int CW = 16;

    bit          clk = 1'b0;
    logic        reset;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_changed;
`ifdef SW_DEBOUNCE_EVENT_EN
    logic [W-1:0] event_clr;
    logic [W-1:0] event_q;
`endif

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] chg;
        logic [W-1:0] ev;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH           (W),
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
`ifdef SW_DEBOUNCE_EVENT_EN
        .event_clr  (event_clr),
        .event_q    (event_q),
`endif
        .sw_out     (sw_out),
        .sw_changed (sw_changed)
    );

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s [%s] t=%0t actual=%h required=%h", phase, nm, $time, act, req);
        end
    endtask

    // Advance n edges, then move 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: evaluated with the inputs present at each rising edge.
    initial begin : model
        logic [W-1:0] m_s1, m_out, m_chg, m_ev, clr_v;
        logic [W-1:0] hist [D];   // hist[0] = newest synchronized sample
        logic         all_diff;
        m_s1 = '0; m_out = '0; m_chg = '0; m_ev = '0;
        for (int k = 0; k < D; k++) hist[k] = '0;
        forever begin
            @(posedge clk);
`ifdef SW_DEBOUNCE_EVENT_EN
            clr_v = event_clr;
`else
            clr_v = '0;
`endif
            if (reset) begin
                m_s1 = '0; m_out = '0; m_chg = '0; m_ev = '0;
                for (int k = 0; k < D; k++) hist[k] = '0;
            end else begin
                m_ev = (m_ev & ~clr_v) | m_chg;
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (hist[k][i] == m_out[i]) all_diff = 1'b0;
                    m_chg[i] = all_diff;
                    if (all_diff) m_out[i] = ~m_out[i];
                end
                for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = m_s1;
                m_s1    = sw_in;
            end
            exp_q.push_back('{out: m_out, chg: m_chg, ev: m_ev});
        end
    end

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin : monitor
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s [scoreboard] t=%0t actual=empty required=entry", phase, $time);
            end else begin
                e = exp_q.pop_front();
                check("sw_out", sw_out, e.out);
                check("sw_changed", sw_changed, e.chg);
`ifdef SW_DEBOUNCE_EVENT_EN
                check("event_q", event_q, e.ev);
`endif
            end
        end
    end

    // Stimulus: directed scenarios with direct timing checks, then random.
    initial begin : stim
        logic [W-1:0] flip;
        reset = 1'b1;
        sw_in = 10'h3FF;
`ifdef SW_DEBOUNCE_EVENT_EN
        event_clr = '0;
`endif
        step(3);
        check("reset_out", sw_out, 10'h000);
        check("reset_chg", sw_changed, 10'h000);
        reset = 1'b0;
        step(5);
        check("held_c5", sw_out, 10'h000);
        step(1);
        check("held_c6_out", sw_out, 10'h3FF);
        check("held_c6_chg", sw_changed, 10'h3FF);
        step(1);
        check("held_c7_chg", sw_changed, 10'h000);

        phase = "all_low";
        sw_in = 10'h000;
        step(10);
        check("all_low", sw_out, 10'h000);

        phase = "bit3_rise";
        sw_in[3] = 1'b1;
        step(5);
        check("bit3_e5", sw_out, 10'h000);
        step(1);
        check("bit3_e6_out", sw_out, 10'h008);
        check("bit3_e6_chg", sw_changed, 10'h008);
        step(4);

        phase = "bit0_bounce";
        sw_in[0] = 1'b1; step(3);
        sw_in[0] = 1'b0; step(1);
        sw_in[0] = 1'b1; step(5);
        check("bit0_e5", sw_out, 10'h008);
        step(1);
        check("bit0_e6_out", sw_out, 10'h009);
        check("bit0_e6_chg", sw_changed, 10'h001);
        step(4);

        phase = "bits1_8";
        sw_in = sw_in | 10'h102;
        step(5);
        check("b18_e5", sw_out, 10'h009);
        step(1);
        check("b18_e6_out", sw_out, 10'h10B);
        check("b18_e6_chg", sw_changed, 10'h102);
        step(4);

        phase = "bit5_reset";
        sw_in[5] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        check("b5_in_reset", sw_out, 10'h000);
        reset = 1'b0;
        step(5);
        check("b5_e5", sw_out, 10'h000);
        step(1);
        check("b5_e6", sw_out, 10'h12B);
        step(4);

`ifdef SW_DEBOUNCE_EVENT_EN
        phase = "event";
        sw_in[2] = 1'b1;
        step(6);
        check("ev_chg2", sw_changed & 10'h004, 10'h004);
        step(1);
        check("ev_set", event_q & 10'h004, 10'h004);
        step(3);
        check("ev_hold", event_q & 10'h004, 10'h004);
        event_clr[2] = 1'b1; step(1); event_clr[2] = 1'b0;
        check("ev_clr", event_q & 10'h004, 10'h000);
        sw_in[2] = 1'b0;
        step(6);
        event_clr[2] = 1'b1; step(1); event_clr[2] = 1'b0;
        check("ev_set_wins", event_q & 10'h004, 10'h004);
        step(4);
`endif

        phase = "random";
        for (int c = 0; c < 600; c++) begin
            flip = '0;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) flip[i] = 1'b1;
            sw_in = sw_in ^ flip;
            reset = ($urandom_range(0, 199) == 0);
`ifdef SW_DEBOUNCE_EVENT_EN
            event_clr = W'($urandom_range(0, 1023)) & W'($urandom_range(0, 1023));
`endif
            step(1);
        end
        reset = 1'b0;
        phase = "drain";
        step(8);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain [scoreboard] actual=%0d entries required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
